// File: rtl/i2c_rcv_buffer.sv
// i2c_rcv_buffer: first-word-fall-through receive FIFO behind the I2C master.
// Each accepted byte is queued with its E2PROM address. The buffer also keeps a
// sticky overflow flag and a saturating count of master error events.
// Build option: define RCV_ADDR_TAG_EN to store {address, data} (16-bit entries).
// Without it, only the data byte is stored and o_Rd_Data is 8 bits wide.
// DEPTH must be 2, 4, 8 or 16, so the pointers wrap naturally at their width.
module i2c_rcv_buffer #(
    parameter int DEPTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 o_clk10MHz,
    input  logic                 i_RST_n,
    input  logic [7:0]           i_Rcv_Data,
    input  logic [7:0]           i_Rcv_Addr,
    input  logic                 i_Rcv_Stb,
    input  logic                 i_Err_Flag,
    input  logic                 i_Flush,
`ifdef RCV_ADDR_TAG_EN
    output logic [15:0]          o_Rd_Data,
`else
    output logic [7:0]           o_Rd_Data,
`endif
    output logic                 o_Rd_Valid,
    input  logic                 i_Rd_Ready,
    output logic [4:0]           o_Count,
    output logic                 o_Full,
    output logic                 o_Empty,
    output logic                 o_Overflow,
    output logic [ERR_CNT_W-1:0] o_Err_Cnt
);

`ifdef RCV_ADDR_TAG_EN
    localparam int ENTRY_W = 16;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]        wrPtr_q, wrPtr_d;
    logic [AW-1:0]        rdPtr_q, rdPtr_d;
    logic [4:0]           count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
    logic                 errPrev_q;
    logic                 run_q;

    logic [ENTRY_W-1:0]   entry;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 errEvent;

`ifdef RCV_ADDR_TAG_EN
    assign entry = {i_Rcv_Addr, i_Rcv_Data};
`else
    logic unusedAddr;
    assign unusedAddr = ^i_Rcv_Addr;
    assign entry      = i_Rcv_Data;
`endif

    // run_q stays low on the edge that releases reset, so that edge does no push or pop
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == 5'd0);
    assign pop      = run_q & ~empty & i_Rd_Ready;
    assign push     = run_q & i_Rcv_Stb & ~i_Err_Flag & (~full | pop);
    assign drop     = run_q & i_Rcv_Stb & ~i_Err_Flag & full & ~pop;
    assign errEvent = i_Err_Flag & ~errPrev_q;

    // Next-state logic: flush wins over push, pop and error counting
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        errCnt_d   = errCnt_q;
        if (i_Flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = 5'd0;
            overflow_d = 1'b0;
            errCnt_d   = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + 5'd1;
            end else if (pop && !push) begin
                count_d = count_q - 5'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (errEvent && (errCnt_q != '1)) begin
                errCnt_d = errCnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge o_clk10MHz or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            errCnt_q   <= '0;
            errPrev_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            errCnt_q   <= errCnt_d;
            errPrev_q  <= i_Err_Flag;
            run_q      <= 1'b1;
        end
    end

    // Storage array is written on an accepted push and is never reset
    always_ff @(posedge o_clk10MHz) begin
        if (push && !i_Flush) begin
            mem_q[wrPtr_q] <= entry;
        end
    end

    assign o_Rd_Data  = mem_q[rdPtr_q];
    assign o_Rd_Valid = ~empty;
    assign o_Count    = count_q;
    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Overflow = overflow_q;
    assign o_Err_Cnt  = errCnt_q;

endmodule

// File: tb/tb_i2c_rcv_buffer.sv
// Testbench for i2c_rcv_buffer (DEPTH 8, ERR_CNT_W 8).
// It uses a vector table, hand-written corner sequences and a randomized run.
// All results are compared against a queue-based reference model.
module tb_i2c_rcv_buffer;

    localparam int DEPTH     = 8;
    localparam int ERR_CNT_W = 8;
`ifdef RCV_ADDR_TAG_EN
    localparam int ENTRY_W = 16;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam int ERR_MAX = (1 << ERR_CNT_W) - 1;

    logic                 clk;
    logic                 rstN;
    logic [7:0]           rcvData;
    logic [7:0]           rcvAddr;
    logic                 rcvStb;
    logic                 errFlag;
    logic                 flush;
    logic [ENTRY_W-1:0]   rdData;
    logic                 rdValid;
    logic                 rdReady;
    logic [4:0]           count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic [ERR_CNT_W-1:0] errCnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq[$];
    logic        mOvf;
    int          mErrCnt;
    logic        mPrevErr;

    typedef struct {
        logic        stb;
        logic [7:0]  data;
        logic [7:0]  addr;
        logic        flush;
        logic        rdy;
        int          expCount;
        logic        expOvf;
        logic [15:0] expHead;
    } vec_t;

    vec_t vecs[$];

    i2c_rcv_buffer #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .o_clk10MHz (clk),
        .i_RST_n    (rstN),
        .i_Rcv_Data (rcvData),
        .i_Rcv_Addr (rcvAddr),
        .i_Rcv_Stb  (rcvStb),
        .i_Err_Flag (errFlag),
        .i_Flush    (flush),
        .o_Rd_Data  (rdData),
        .o_Rd_Valid (rdValid),
        .i_Rd_Ready (rdReady),
        .o_Count    (count),
        .o_Full     (full),
        .o_Empty    (empty),
        .o_Overflow (overflow),
        .o_Err_Cnt  (errCnt)
    );

    // 10 MHz clock
    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [31:0] expEntry(input logic [15:0] e);
`ifdef RCV_ADDR_TAG_EN
        return {16'h0, e};
`else
        return {24'h0, e[7:0]};
`endif
    endfunction

    function automatic void addVec(input logic stb, input logic [7:0] data, input logic [7:0] addr,
                                   input logic fl, input logic rdy, input int expCount,
                                   input logic expOvf, input logic [15:0] expHead);
        vec_t v;
        v.stb = stb; v.data = data; v.addr = addr; v.flush = fl; v.rdy = rdy;
        v.expCount = expCount; v.expOvf = expOvf; v.expHead = expHead;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf     = 1'b0;
        mErrCnt  = 0;
        mPrevErr = 1'b0;
    endtask

    // Reference model: one clock edge of FIFO behaviour from the sampled inputs
    task automatic modelStep();
        logic doPop;
        logic isFull;
        if (flush) begin
            mq.delete();
            mOvf    = 1'b0;
            mErrCnt = 0;
        end else begin
            doPop  = (mq.size() > 0) && rdReady;
            isFull = (mq.size() == DEPTH);
            if (doPop) void'(mq.pop_front());
            if (rcvStb && !errFlag) begin
                if (!isFull || doPop) mq.push_back({rcvAddr, rcvData});
                else mOvf = 1'b1;
            end
            if (errFlag && !mPrevErr && mErrCnt < ERR_MAX) mErrCnt++;
        end
        mPrevErr = errFlag;
    endtask

    task automatic applyStimulus(input logic stb, input logic [7:0] data, input logic [7:0] addr,
                                 input logic err, input logic fl, input logic rdy);
        rcvStb  = stb;
        rcvData = data;
        rcvAddr = addr;
        errFlag = err;
        flush   = fl;
        rdReady = rdy;
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, " count"}, 32'(count), 32'(mq.size()));
        checkVal({name, " empty"}, 32'(empty), 32'(mq.size() == 0));
        checkVal({name, " full"}, 32'(full), 32'(mq.size() == DEPTH));
        checkVal({name, " valid"}, 32'(rdValid), 32'(mq.size() != 0));
        checkVal({name, " overflow"}, 32'(overflow), 32'(mOvf));
        checkVal({name, " errCnt"}, 32'(errCnt), 32'(mErrCnt));
        if (mq.size() > 0) checkVal({name, " data"}, 32'(rdData), expEntry(mq[0]));
    endtask

    task automatic checkResetState(input string name);
        checkVal({name, " count"}, 32'(count), 32'd0);
        checkVal({name, " empty"}, 32'(empty), 32'd1);
        checkVal({name, " full"}, 32'(full), 32'd0);
        checkVal({name, " valid"}, 32'(rdValid), 32'd0);
        checkVal({name, " overflow"}, 32'(overflow), 32'd0);
        checkVal({name, " errCnt"}, 32'(errCnt), 32'd0);
    endtask

    // Main test sequence
    initial begin
        logic rdyLevel;
        logic errLevel;

        rstN = 1'b0; rcvStb = 1'b0; rcvData = 8'h0; rcvAddr = 8'h0;
        errFlag = 1'b0; flush = 1'b0; rdReady = 1'b0;
        modelReset();

        // Vector table: push/pop, fill to overflow, full push+pop, drain, flush
        addVec(1'b1, 8'hA5, 8'h80, 1'b0, 1'b1, 1, 1'b0, 16'h80A5);
        addVec(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, 16'h0000);
        for (int k = 1; k <= 9; k++)
            addVec(1'b1, 8'(k), 8'(8'h20 + k), 1'b0, 1'b0, (k > 8) ? 8 : k, (k == 9), 16'h2101);
        addVec(1'b1, 8'h0A, 8'h2A, 1'b0, 1'b1, 8, 1'b1, 16'h2202);
        for (int j = 0; j < 8; j++)
            addVec(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 7 - j, 1'b1,
                   (j < 6) ? 16'(16'h2303 + 16'h0101 * j) : 16'h2A0A);
        addVec(1'b1, 8'h77, 8'h77, 1'b1, 1'b0, 0, 1'b0, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("release");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stb, vecs[i].data, vecs[i].addr, 1'b0, vecs[i].flush, vecs[i].rdy);
            checkVal($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].expCount));
            checkVal($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
            if (vecs[i].expCount > 0)
                checkVal($sformatf("vec%0d head", i), 32'(rdData), expEntry(vecs[i].expHead));
            checkOutput($sformatf("vec%0d", i));
        end

        // 300 error pulses with one strobe during a high level
        for (int p = 0; p < 300; p++) begin
            applyStimulus(p == 150, 8'h99, 8'h99, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            if (p == 2) checkVal("err cnt after 3", 32'(errCnt), 32'd3);
        end
        checkVal("err cnt saturated", 32'(errCnt), 32'(ERR_MAX));
        checkVal("err strobe not stored", 32'(count), 32'd0);
        checkOutput("errPulses");

        // Fill past full, then flush with a strobe and a rising error edge
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'(8'h40 + k), 8'(8'h50 + k), 1'b0, 1'b0, 1'b0);
        checkVal("prefill overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b1, 1'b1, 1'b1);
        checkVal("flush count", 32'(count), 32'd0);
        checkVal("flush overflow", 32'(overflow), 32'd0);
        checkVal("flush errCnt", 32'(errCnt), 32'd0);
        checkVal("flush empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkVal("held err not recounted", 32'(errCnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkVal("new err edge", 32'(errCnt), 32'd1);
        applyStimulus(1'b1, 8'h31, 8'h13, 1'b0, 1'b0, 1'b0);
        checkVal("post flush head", 32'(rdData), expEntry(16'h1331));
        checkOutput("postFlush");

        // Reset in the middle of operation, strobe held across release
        applyStimulus(1'b1, 8'h61, 8'h16, 1'b0, 1'b0, 1'b0);
        rcvStb = 1'b1; rcvData = 8'h5C; rcvAddr = 8'hC5;
        #20;
        rstN = 1'b0;
        #1;
        checkResetState("midReset");
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkVal("release edge no push", 32'(count), 32'd0);
        checkOutput("releaseEdge");
        applyStimulus(1'b1, 8'h5C, 8'hC5, 1'b0, 1'b0, 1'b0);
        checkVal("first push after reset", 32'(rdData), expEntry(16'hC55C));
        checkOutput("afterReset");

        // 20 push/pop pairs with ready toggling across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i * 7), 8'(8'hF0 - i), 1'b0, 1'b0, i[0]);
            checkOutput($sformatf("pair%0d", i));
        end

        // Randomized traffic against the model
        rdyLevel = 1'b0;
        errLevel = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) rdyLevel = ~rdyLevel;
            if ($urandom_range(0, 19) == 0) errLevel = ~errLevel;
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), errLevel,
                          ($urandom_range(0, 99) == 0), rdyLevel);
            checkOutput($sformatf("rand%0d", c));
            checkVal($sformatf("rand%0d count bound", c), 32'(count <= 5'(DEPTH)), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_rcv_buffer.md
I2C_RCV_BUFFER -- requirements
Module: i2c_rcv_buffer

Interface
- REQ-001: Parameter DEPTH, default 8, FIFO entries; legal values 2, 4, 8 or 16 only.
- REQ-002: Parameter ERR_CNT_W, default 8, width of error counter.
- REQ-003: o_clk10MHz  input  1  system clock, 10 MHz from PLL.
- REQ-004: i_RST_n  input  1  reset, asynchronous, active-low.
- REQ-005: i_Rcv_Data  input  8  received byte from I2C master.
- REQ-006: i_Rcv_Addr  input  8  E2PROM address of received byte.
- REQ-007: i_Rcv_Stb  input  1  one-cycle strobe, i_Rcv_Data/i_Rcv_Addr valid.
- REQ-008: i_Err_Flag  input  1  master transaction-error level.
- REQ-009: i_Flush  input  1  synchronous clear of FIFO and sticky flags.
- REQ-010: o_Rd_Data  output  16 (tag on) / 8 (tag off)  head entry, first-word-fall-through.
- REQ-011: o_Rd_Valid  output  1  head entry present.
- REQ-012: i_Rd_Ready  input  1  consumer accepts head when o_Rd_Valid high.
- REQ-013: o_Count  output  5  occupied entries, 0..DEPTH.
- REQ-014: o_Full / o_Empty  output  1 each  Count==DEPTH / Count==0.
- REQ-015: o_Overflow  output  1  sticky, byte dropped while full.
- REQ-016: o_Err_Cnt  output  ERR_CNT_W  saturating count of error events.

Function
- REQ-017: Push = i_Rcv_Stb high AND i_Err_Flag low AND (not full OR pop in same cycle).
- REQ-018: Pop = o_Rd_Valid AND i_Rd_Ready.
- REQ-019: Stored entry = {i_Rcv_Addr, i_Rcv_Data} sampled on push clock edge.
- REQ-020: Push-to-visible latency: o_Rd_Valid high and o_Rd_Data valid the cycle after the push edge; no zero-cycle bypass.
- REQ-021: o_Rd_Data = head entry combinationally from storage; stable while o_Rd_Valid high and no pop.
- REQ-022: o_Rd_Valid = not o_Empty.
- REQ-023: Pointers DEPTH-modulo, wrap from DEPTH-1 to 0 without gap.
- REQ-024: Push and pop same cycle: Count unchanged; full case accepts the push (no overflow).
- REQ-025: Empty and i_Rcv_Stb: push only; no pop possible that cycle.
- REQ-026: i_Rcv_Stb while full and no pop: byte dropped, o_Overflow set next edge, storage unchanged.
- REQ-027: i_Rcv_Stb with i_Err_Flag high: byte discarded, o_Overflow unaffected.
- REQ-028: Error event = i_Err_Flag rising edge (registered previous value, reset 0); o_Err_Cnt increments by 1, holds at all-ones.
- REQ-029: i_Flush high: pointers, Count, o_Overflow, o_Err_Cnt cleared next edge; overrides same-cycle push, pop and error event.
- REQ-030: Flush does not clear the i_Err_Flag edge-detect register; a level held through flush is not recounted.

Reset
- REQ-031: On i_RST_n low, immediately: pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Rd_Valid 0, o_Overflow 0, o_Err_Cnt 0, edge-detect register 0.
- REQ-032: Storage array not reset; o_Rd_Data don't-care while o_Rd_Valid low.
- REQ-033: Reset mid-operation discards all entries; first push after release is entry 0.
- REQ-034: Reset deassertion sampled synchronously; no push/pop on the release edge.

Configuration
- REQ-035: Macro RCV_ADDR_TAG_EN defined: entry 16 bits, o_Rd_Data[15:8]=address, [7:0]=data.
- REQ-036: Macro RCV_ADDR_TAG_EN undefined: entry 8 bits, o_Rd_Data = data only, i_Rcv_Addr unused; all other behaviour identical.

Verification
- REQ-037: Reset, push 0xA5@0x80, Ready high -> o_Rd_Valid one cycle after push, o_Rd_Data 0x80A5 (tag on) / 0xA5 (off), then Empty.
- REQ-038: Ready low, 9 strobes data 0x01..0x09, DEPTH 8 -> Full after 8, o_Overflow 1, drain returns 0x01..0x08 in order.
- REQ-039: Full FIFO, strobe + pop same cycle -> Count stays 8, no overflow, new byte read last.
- REQ-040: i_Err_Flag pulses 300 times (ERR_CNT_W 8), one strobe during high level -> o_Err_Cnt 255, byte not stored.
- REQ-041: 3 entries, then i_Flush with simultaneous strobe -> Count 0, Overflow 0, Err_Cnt 0, strobe byte absent.
- REQ-042: 20 push/pop pairs with Ready toggling -> pointer wrap, data order preserved, Count never exceeds 8.
